// File: rtl/evo_pkg.sv
// Shared sizes and FSM state encoding for the truth-table scorer.
// Imported by the interface, the scorer and its bench.
package evo_pkg;

    localparam int NUM_INPUTS  = 4;
    localparam int NUM_OUTPUTS = 4;
    localparam int NUM_VECTORS = 16;
    localparam int TARGET_W    = 64;
    localparam int SCORE_W     = 7;

    localparam logic [SCORE_W-1:0]    SCORE_MAX = SCORE_W'(TARGET_W);
    localparam logic [NUM_INPUTS-1:0] LAST_VEC  = NUM_INPUTS'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_scorer_if.sv
// Bundle between the scorer and whoever requests an evaluation and hosts the
// candidate circuit. The slave side is the scorer itself.
interface truth_table_scorer_if;
    import evo_pkg::*;

    logic                   start;
    logic [TARGET_W-1:0]    target;
    logic [NUM_INPUTS-1:0]  dut_in;
    logic [NUM_OUTPUTS-1:0] dut_out;
    logic                   busy;
    logic                   done;
    logic [SCORE_W-1:0]     score;
    logic [NUM_OUTPUTS-1:0] miss_mask;
    logic                   perfect;

    modport master (
        output start, target, dut_out,
        input  dut_in, busy, done, score, miss_mask, perfect
    );

    modport slave (
        input  start, target, dut_out,
        output dut_in, busy, done, score, miss_mask, perfect
    );

endinterface

// File: rtl/popcount4.sv
// Number of set bits in a 4-bit word (0..4).
module popcount4 (
    input  logic [3:0] a,
    output logic [2:0] cnt
);

    assign cnt = 3'(a[0]) + 3'(a[1]) + 3'(a[2]) + 3'(a[3]);

endmodule

// File: rtl/truth_table_scorer.sv
// Walks all 16 input vectors through a candidate circuit, lets each settle,
// and scores how many output bits agree with the latched target table.
module truth_table_scorer
    import evo_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    truth_table_scorer_if.slave bus
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e                 state;
    logic [TARGET_W-1:0]    target_q;
    logic [NUM_INPUTS-1:0]  vec;
    logic [7:0]             wait_cnt;
    logic [SCORE_W-1:0]     score_q;
    logic [NUM_OUTPUTS-1:0] miss_q;

    logic [NUM_OUTPUTS-1:0] expected;
    logic [NUM_OUTPUTS-1:0] diff;
    logic [2:0]             match_cnt;

    assign expected = target_q[{vec, 2'b00} +: NUM_OUTPUTS];
    assign diff     = bus.dut_out ^ expected;

    popcount4 u_popcount4 (
        .a   (~diff),
        .cnt (match_cnt)
    );

    // NOTE: every register sits on the async reset, so an abort leaves no
    // stale partial score or pending done behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target_q <= '0;
            vec      <= '0;
            wait_cnt <= '0;
            score_q  <= '0;
            miss_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Target is captured here so the requester may move on.
                    if (bus.start) begin
                        target_q <= bus.target;
                        vec      <= '0;
                        wait_cnt <= '0;
                        score_q  <= '0;
                        miss_q   <= '0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == SETTLE_LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    score_q <= score_q + SCORE_W'(match_cnt);
                    miss_q  <= miss_q | diff;
                    if (vec == LAST_VEC) begin
                        state <= DONE;
                    end else begin
                        vec      <= vec + 1'b1;
                        wait_cnt <= '0;
                        state    <= SETTLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in    = vec;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.score     = score_q;
    assign bus.miss_mask = miss_q;
    assign bus.perfect   = (score_q == SCORE_MAX);

endmodule

// File: doc/truth_table_scorer.md
TRUTH_TABLE_SCORER -- requirements
Module: truth_table_scorer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles each input vector is held before sampling; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request evaluation; accepted only in IDLE.
REQ-005 target  input  64  expected truth table; nibble target[4v+3:4v] = expected {out3,out2,out1,out0} for input vector v.
REQ-006 dut_in  output  4  stimulus to candidate circuit; {input3,input2,input1,input0}.
REQ-007 dut_out  input  4  candidate response; {output3,output2,output1,output0}.
REQ-008 busy  output  1  high from start acceptance until DONE state exits.
REQ-009 done  output  1  one-cycle pulse; score, miss_mask and perfect valid.
REQ-010 score  output  7  count of matching output bits, 0..64.
REQ-011 miss_mask  output  4  bit k set if output k mismatched in any vector.
REQ-012 perfect  output  1  high when score == 64.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1: latch target, vec<=0, dut_in<=0, score<=0, miss_mask<=0, wait counter<=0, go SETTLE.
REQ-015 SETTLE: hold dut_in=vec; increment wait counter; after SETTLE_CYCLES cycles in SETTLE go SAMPLE.
REQ-016 SAMPLE (one cycle): score += popcount(~(dut_out ^ latched nibble vec)); miss_mask |= dut_out ^ nibble; if vec==15 go DONE, else vec<=vec+1, dut_in<=vec+1, counter<=0, go SETTLE.
REQ-017 DONE (one cycle): done=1, busy=1; next state IDLE.
REQ-018 done SHALL be high exactly one cycle, beginning 16*(SETTLE_CYCLES+1) rising edges after the start-accept edge.
REQ-019 score, miss_mask, perfect SHALL hold their values after DONE until the next start acceptance.
REQ-020 start while busy SHALL be ignored; target changes after acceptance SHALL not affect the result.
REQ-021 score arithmetic 7 bits unsigned; maximum 64 reachable without overflow.
REQ-022 dut_out SHALL be sampled only in SAMPLE; values during SETTLE are don't-care (candidate gate delays).
REQ-023 vec wraps never: evaluation ends at vec 15.

Reset
REQ-024 On rst_n low, immediately: state IDLE, dut_in=0, busy=0, done=0, score=0, miss_mask=0, perfect=0, counters 0.
REQ-025 Reset mid-evaluation SHALL abort without a done pulse; a new start after release begins a fresh run.

Structure
REQ-026 Shared package evo_pkg SHALL hold NUM_INPUTS=4, NUM_OUTPUTS=4, NUM_VECTORS=16, TARGET_W=64, SCORE_W=7 and the FSM state enum.
REQ-027 One sub-module popcount4 (4-bit in, 3-bit count) SHALL compute per-vector match count.

Verification
REQ-028 target=64'hFFFF_FFFF_FFFF_FFFF, dut_out tied 4'hF -> score 64, perfect 1, miss_mask 0.
REQ-029 target=0, dut_out tied 4'hF -> score 0, perfect 0, miss_mask 4'hF.
REQ-030 dut_out=dut_in (identity), target=64'hFEDC_BA98_7654_3210 -> score 64; dut_in steps 0..15 in order.
REQ-031 SETTLE_CYCLES=4, start pulse -> done exactly 80 edges after accept, busy high throughout; second start mid-run ignored.
REQ-032 rst_n low at vector 7 -> all outputs 0 immediately, no done; subsequent start yields correct full result.
REQ-033 target=0, dut_out={0,0,0,dut_in[0]} -> score 56, miss_mask 4'b0001.
